// File: rtl/router_1xn_if.sv
// Bus between the packet source, the N consumers and router_1xn.
//
// Handshake: the source presents pkt_valid/data_in; a beat is taken on a
// rising clock edge only while busy is low. While busy is high the source
// must hold pkt_valid and data_in unchanged. read_enb[i] pops one entry from
// output FIFO i on the edge it is sampled high, provided vld_out[i] is high.
// fsm_state mirrors the router's internal state for debug and checkers.
interface router_1xn_if #(
  parameter int DW        = 8,
  parameter int NUM_PORTS = 3
);
  logic                    pkt_valid;
  logic [DW-1:0]           data_in;
  logic [NUM_PORTS-1:0]    read_enb;
  logic [NUM_PORTS*DW-1:0] data_out;
  logic [NUM_PORTS-1:0]    vld_out;
  logic                    busy;
  logic                    error;
  logic [2:0]              fsm_state;

  modport master (
    output pkt_valid, data_in, read_enb,
    input  data_out, vld_out, busy, error, fsm_state
  );

  modport slave (
    input  pkt_valid, data_in, read_enb,
    output data_out, vld_out, busy, error, fsm_state
  );
endinterface

// File: rtl/router_1xn.sv
// router_1xn: byte-serial 1xN packet router with per-port output FIFOs.
// Header = {length, addr}; illegal addresses are dropped; parity is checked
// per packet and mismatches raise a one-cycle error pulse.
// Optional feature macro: ROUTER_SOFT_RESET_EN (per-port unread timeout flush).
module router_1xn #(
  parameter int DW        = 8,
  parameter int NUM_PORTS = 3,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 30
) (
  input logic         clock,
  input logic         resetn,
  router_1xn_if.slave bus
);
  localparam int AW  = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AWF = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_DROP  = 3'd4
  } state_e;

  state_e               state;
  logic [AW-1:0]        dest;
  logic [DW-1:0]        hdr_q;
  logic [DW-1:0]        parity_q;
  logic                 error_q;
  logic                 busy_c;

  logic [AW-1:0]        addr_in;
  logic                 addr_ok;
  logic [NUM_PORTS-1:0] addr_oh;
  logic [NUM_PORTS-1:0] dest_oh;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] flush;
  logic [NUM_PORTS-1:0] wr_oh;
  logic [DW-1:0]        wr_data;
  logic                 addr_empty;
  logic                 dest_empty;
  logic                 dest_full;
  logic                 dest_flush;

  assign addr_in = bus.data_in[AW-1:0];
  assign addr_ok = (int'(addr_in) < NUM_PORTS);

  // One-hot decode of the incoming header address and the latched destination.
  always_comb begin
    addr_oh = '0;
    dest_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_oh[i] = (addr_in == AW'(i));
      dest_oh[i] = (dest == AW'(i));
    end
  end

  assign addr_empty = |(addr_oh & empty);
  assign dest_empty = |(dest_oh & empty);
  assign dest_full  = |(dest_oh & full);
  assign dest_flush = |(dest_oh & flush);

  // busy is a pure decode of state and destination fullness, so it never
  // depends combinationally on the source's inputs.
  always_comb begin
    case (state)
      S_WAIT, S_CHECK: busy_c = 1'b1;
      S_LOAD:          busy_c = dest_full;
      default:         busy_c = 1'b0;
    endcase
  end

  // Select which FIFO (if any) is written this cycle and with what byte.
  always_comb begin
    wr_oh   = '0;
    wr_data = bus.data_in;
    case (state)
      S_IDLE: if (bus.pkt_valid && addr_ok && addr_empty) wr_oh = addr_oh;
      S_WAIT: if (dest_empty) begin
        wr_oh   = dest_oh;
        wr_data = hdr_q;
      end
      S_LOAD: if (!dest_full) wr_oh = dest_oh;
      default: ;
    endcase
    // A port being flushed on this edge must not take a write.
    wr_oh = wr_oh & ~flush;
  end

  // Packet FSM: header decode, loading, parity check and discard.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      dest     <= '0;
      hdr_q    <= '0;
      parity_q <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.pkt_valid) begin
            if (addr_ok) begin
              dest     <= addr_in;
              hdr_q    <= bus.data_in;
              parity_q <= bus.data_in;
              state    <= addr_empty ? S_LOAD : S_WAIT;
            end else begin
              state <= S_DROP;
            end
          end
        end
        S_WAIT: begin
          if (dest_flush)      state <= S_DROP;
          else if (dest_empty) state <= S_LOAD;
        end
        S_LOAD: begin
          if (dest_flush) begin
            // If the parity beat itself is consumed on the flush edge the
            // packet is over; otherwise the remainder must be discarded.
            state <= (!dest_full && !bus.pkt_valid) ? S_IDLE : S_DROP;
          end else if (!dest_full) begin
            if (bus.pkt_valid) begin
              parity_q <= parity_q ^ bus.data_in;
            end else begin
              error_q <= (parity_q != bus.data_in);
              state   <= S_CHECK;
            end
          end
        end
        S_CHECK: state <= dest_flush ? S_DROP : S_IDLE;
        S_DROP:  if (!bus.pkt_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.error     = error_q;
  assign bus.fsm_state = state;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [AWF:0]  wptr;
    logic [AWF:0]  rptr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout;
    logic          rd;

    // The extra top bit distinguishes full from empty when the indices match.
    assign empty[g] = (wptr == rptr);
    assign full[g]  = (wptr[AWF] != rptr[AWF]) && (wptr[AWF-1:0] == rptr[AWF-1:0]);
    assign rd       = bus.read_enb[g] && !empty[g];

    // Storage array; written only when the FSM selects this port.
    always_ff @(posedge clock) begin
      if (wr_oh[g]) mem[wptr[AWF-1:0]] <= wr_data;
    end

    // Pointers and registered read data; a read of an empty FIFO is ignored.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wptr <= '0;
        rptr <= '0;
        dout <= '0;
      end else if (flush[g]) begin
        wptr <= '0;
        rptr <= '0;
        dout <= '0;
      end else begin
        if (wr_oh[g]) wptr <= wptr + 1'b1;
        if (rd) begin
          dout <= mem[rptr[AWF-1:0]];
          rptr <= rptr + 1'b1;
        end
      end
    end

    assign bus.data_out[g*DW +: DW] = dout;
    assign bus.vld_out[g]           = !empty[g];

`ifdef ROUTER_SOFT_RESET_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] idle_cnt;
    logic          stale;

    assign stale = !empty[g] && !bus.read_enb[g];
    // The flush fires on the edge where the count would step to TIMEOUT.
    assign flush[g] = stale && (idle_cnt == CW'(TIMEOUT - 1));

    // Count consecutive cycles this port holds data without being read.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                 idle_cnt <= '0;
      else if (stale && !flush[g]) idle_cnt <= idle_cnt + 1'b1;
      else                         idle_cnt <= '0;
    end
`else
    // Without the soft-reset feature TIMEOUT has no effect.
    assign flush[g] = 1'b0 & (TIMEOUT == 0);
`endif
  end
endmodule

// File: tb/tb_router_1xn.sv
// Self-checking bench for router_1xn: directed scenarios plus a randomized
// run, checked against per-port expected byte queues built from packet rules.
module tb_router_1xn;
  localparam int DW      = 8;
  localparam int NP      = 3;
  localparam int AW      = 2;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;
  localparam int LIMIT   = 2000;

  logic clock;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  bit   send_done;

  logic [DW-1:0] exp_q [NP][$];
  logic [DW-1:0] pay_q [$];

  router_1xn_if #(.DW(DW), .NUM_PORTS(NP)) bus ();

  router_1xn #(
    .DW(DW), .NUM_PORTS(NP), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Offer one beat from a negedge; return at the negedge after it is taken.
  task automatic drive_beat(input logic v, input logic [DW-1:0] d, output int waits);
    waits = 0;
    bus.pkt_valid = v;
    bus.data_in   = d;
    while (bus.busy !== 1'b0 && waits < LIMIT) begin
      @(negedge clock);
      waits++;
    end
    if (waits >= LIMIT) begin
      checks++; errors++;
      $display("FAIL beat_accept: busy=%b after %0d cycles, required 0", bus.busy, waits);
    end
    @(negedge clock);
  endtask

  // Send header, the bytes in pay_q, then a parity byte (true XOR unless forced).
  task automatic send_packet(input logic [DW-1:0] hdr, input bit force_par,
                             input logic [DW-1:0] par_val, output int waits_total);
    logic [DW-1:0] x;
    logic [DW-1:0] p;
    int            w;
    int            port;
    bit            good;
    bit            exp_err;
    port = int'(hdr[AW-1:0]);
    good = (port < NP);
    waits_total = 0;
    x = hdr;
    foreach (pay_q[k]) x ^= pay_q[k];
    p = force_par ? par_val : x;
    exp_err = good && (p != x);
    if (good) begin
      exp_q[port].push_back(hdr);
      foreach (pay_q[k]) exp_q[port].push_back(pay_q[k]);
      exp_q[port].push_back(p);
    end
    drive_beat(1'b1, hdr, w); waits_total += w;
    foreach (pay_q[k]) begin
      drive_beat(1'b1, pay_q[k], w); waits_total += w;
    end
    drive_beat(1'b0, p, w); waits_total += w;
    bus.pkt_valid = 1'b0;
    checks++;
    if (bus.error !== exp_err) begin
      errors++; $display("FAIL error_pulse hdr=%h: got %b, required %b", hdr, bus.error, exp_err);
    end
    if (good) begin
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++; $display("FAIL busy_check hdr=%h: got %b, required 1", hdr, bus.busy);
      end
    end
    @(negedge clock);
    checks++;
    if (bus.error !== 1'b0) begin
      errors++; $display("FAIL error_width hdr=%h: got %b, required 0", hdr, bus.error);
    end
    if (good) begin
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++; $display("FAIL busy_after hdr=%h: got %b, required 0", hdr, bus.busy);
      end
    end
  endtask

  // Read n bytes from port p with a random gap between reads.
  task automatic drain_port(input int p, input int n, input int gmin, input int gmax);
    logic [DW-1:0] e;
    for (int k = 0; k < n; k++) begin
      int g = 0;
      while (bus.vld_out[p] !== 1'b1 && g < LIMIT) begin
        @(negedge clock);
        g++;
      end
      if (g >= LIMIT) begin
        checks++; errors++;
        $display("FAIL drain_timeout port %0d: vld_out stayed 0, required 1", p);
        return;
      end
      bus.read_enb[p] = 1'b1;
      @(negedge clock);
      bus.read_enb[p] = 1'b0;
      checks++;
      if (exp_q[p].size() == 0) begin
        errors++; $display("FAIL drain_extra port %0d: got %h, required no data", p, bus.data_out[p*DW +: DW]);
      end else begin
        e = exp_q[p].pop_front();
        if (bus.data_out[p*DW +: DW] !== e) begin
          errors++; $display("FAIL drain_data port %0d: got %h, required %h", p, bus.data_out[p*DW +: DW], e);
        end
      end
      repeat ($urandom_range(gmin, gmax)) @(negedge clock);
    end
  endtask

  // Randomly paced consumer for the randomized run.
  task automatic reader(input int p);
    int            cyc = 0;
    logic [DW-1:0] e;
    while (cyc < 20000) begin
      if (bus.vld_out[p] === 1'b1 && $urandom_range(0, 1) == 1) begin
        bus.read_enb[p] = 1'b1;
        @(negedge clock);
        bus.read_enb[p] = 1'b0;
        cyc++;
        checks++;
        if (exp_q[p].size() == 0) begin
          errors++; $display("FAIL rand_extra port %0d: got %h, required no data", p, bus.data_out[p*DW +: DW]);
        end else begin
          e = exp_q[p].pop_front();
          if (bus.data_out[p*DW +: DW] !== e) begin
            errors++; $display("FAIL rand_data port %0d: got %h, required %h", p, bus.data_out[p*DW +: DW], e);
          end
        end
      end else begin
        if (send_done && exp_q[p].size() == 0 && bus.vld_out[p] === 1'b0) break;
        @(negedge clock);
        cyc++;
      end
    end
    if (cyc >= 20000) begin
      checks++; errors++;
      $display("FAIL rand_timeout port %0d: %0d bytes left, required 0", p, exp_q[p].size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h, required 0", bus.data_out); end
    checks++;
    if (bus.vld_out !== '0) begin errors++; $display("FAIL reset_vld_out: got %b, required 0", bus.vld_out); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    checks++;
    if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", bus.error); end
  endtask

  task automatic test_basic(input bit bad_parity);
    int w;
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h0D, bad_parity, 8'h00, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL basic_stall: %0d busy cycles, required 0", w); end
    checks++;
    if (bus.vld_out !== 3'b010) begin errors++; $display("FAIL basic_vld: got %b, required 010", bus.vld_out); end
    drain_port(1, 5, 0, 0);
    checks++;
    if (bus.vld_out !== 3'b000) begin errors++; $display("FAIL basic_empty: got %b, required 000", bus.vld_out); end
  endtask

  task automatic test_bad_addr();
    int w;
    pay_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_packet(8'h13, 1'b0, 8'h00, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL drop_busy: %0d busy cycles, required 0", w); end
    checks++;
    if (bus.vld_out !== 3'b000) begin errors++; $display("FAIL drop_vld: got %b, required 000", bus.vld_out); end
    pay_q = '{8'h5C, 8'h7E, 8'h01};
    send_packet(8'h0E, 1'b0, 8'h00, w);
    checks++;
    if (bus.vld_out !== 3'b100) begin errors++; $display("FAIL drop_follow_vld: got %b, required 100", bus.vld_out); end
    drain_port(2, 5, 0, 1);
  endtask

  task automatic test_full_stall();
    int            w;
    int            ws = 0;
    logic [DW-1:0] b;
    exp_q[0].push_back(8'hFC);
    drive_beat(1'b1, 8'hFC, w); ws += w;
    for (int k = 0; k < DEPTH - 1; k++) begin
      b = DW'($urandom);
      exp_q[0].push_back(b);
      drive_beat(1'b1, b, w); ws += w;
    end
    checks++;
    if (ws != 0) begin errors++; $display("FAIL stall_early: %0d busy cycles, required 0", ws); end
    bus.data_in = 8'hA5;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b, required 1", bus.busy); end
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b, required 1", bus.busy); end
    bus.read_enb[0] = 1'b1;
    @(negedge clock);
    bus.read_enb[0] = 1'b0;
    checks++;
    if (bus.data_out[DW-1:0] !== 8'hFC) begin errors++; $display("FAIL stall_read: got %h, required fc", bus.data_out[DW-1:0]); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_release: got %b, required 0", bus.busy); end
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_refull: got %b, required 1", bus.busy); end
    bus.data_in = 8'h5A;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.vld_out !== '0) begin errors++; $display("FAIL async_vld: got %b, required 0", bus.vld_out); end
    checks++;
    if (bus.data_out !== '0) begin errors++; $display("FAIL async_data: got %h, required 0", bus.data_out); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b, required 0", bus.busy); end
    @(negedge clock);
    bus.pkt_valid = 1'b0;
    resetn = 1'b1;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    @(negedge clock);
  endtask

  task automatic test_wait_wrap();
    int w2 = 0;
    fork
      begin
        int w;
        pay_q.delete();
        for (int k = 0; k < 10; k++) pay_q.push_back(DW'($urandom));
        send_packet(8'h2A, 1'b0, 8'h00, w);
        pay_q.delete();
        for (int k = 0; k < 10; k++) pay_q.push_back(DW'($urandom));
        send_packet(8'h2A, 1'b0, 8'h00, w2);
      end
      drain_port(2, 24, 2, 4);
    join
    checks++;
    if (w2 == 0) begin errors++; $display("FAIL wait_busy: %0d busy cycles, required > 0", w2); end
    checks++;
    if (bus.vld_out !== 3'b000 || exp_q[2].size() != 0) begin
      errors++; $display("FAIL wait_end: vld %b left %0d, required 000 and 0", bus.vld_out, exp_q[2].size());
    end
  endtask

  task automatic test_random();
    send_done = 1'b0;
    fork
      begin
        int w;
        for (int k = 0; k < 20; k++) begin
          int addr = $urandom_range(0, 3);
          int len  = $urandom_range(0, 20);
          pay_q.delete();
          for (int j = 0; j < len; j++) pay_q.push_back(DW'($urandom));
          send_packet(DW'((len << AW) | addr), ($urandom_range(0, 3) == 0), DW'($urandom), w);
        end
        send_done = 1'b1;
      end
      reader(0);
      reader(1);
      reader(2);
    join
  endtask

`ifdef ROUTER_SOFT_RESET_EN
  task automatic test_timeout();
    int            n;
    int            w;
    logic [DW-1:0] b;
    drive_beat(1'b1, 8'h00, w);
    checks++;
    if (bus.vld_out[0] !== 1'b1) begin errors++; $display("FAIL to_rise: got %b, required 1", bus.vld_out[0]); end
    drive_beat(1'b0, 8'h00, w);
    bus.pkt_valid = 1'b0;
    n = 1;
    while (bus.vld_out[0] === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n != TIMEOUT) begin errors++; $display("FAIL to_cycles: got %0d, required %0d", n, TIMEOUT); end
    drive_beat(1'b1, 8'h00, w);
    for (int k = 0; k < 40; k++) begin
      b = DW'($urandom);
      drive_beat(1'b1, b, w);
      checks++;
      if (bus.error !== 1'b0) begin errors++; $display("FAIL to_error: got %b, required 0", bus.error); end
    end
    drive_beat(1'b0, 8'h3C, w);
    bus.pkt_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.vld_out !== 3'b000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL to_flush: vld %b busy %b, required 000 and 0", bus.vld_out, bus.busy);
    end
  endtask
`endif

  initial begin
    resetn        = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    bus.read_enb  = '0;
    send_done     = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    resetn = 1'b1;
    @(negedge clock);
    test_basic(1'b0);
    test_basic(1'b1);
    test_bad_addr();
    test_full_stall();
    test_reset();
    test_wait_wrap();
    test_random();
`ifdef ROUTER_SOFT_RESET_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
